serial_shifter: RTL and testbench

//  Multi-cycle, bit-serial counterpart of the datapath's single-cycle barrel shifter.

---
 rtl/shift_pkg.sv | 15 +
 rtl/shift_step.sv | 22 ++
 rtl/serial_shifter.sv | 100 ++++++++++
 tb/tb_serial_shifter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the serial and combinational shifters.
package shift_pkg;

    localparam logic [1:0] LSL = 2'b00;
    localparam logic [1:0] LSR = 2'b01;
    localparam logic [1:0] ASR = 2'b10;
    localparam logic [1:0] RR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// One-position shift/rotate step, selected by opcode.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [1:0]       control,
    input  logic [WIDTH-1:0] r_in,
    output logic [WIDTH-1:0] r_out
);

    always_comb begin
        r_out = r_in;
        case (control)
            LSL:     r_out = {r_in[WIDTH-2:0], 1'b0};
            LSR:     r_out = {1'b0, r_in[WIDTH-1:1]};
            ASR:     r_out = {r_in[WIDTH-1], r_in[WIDTH-1:1]};
            default: r_out = {r_in[0], r_in[WIDTH-1:1]};
        endcase
    end

endmodule

// File: rtl/serial_shifter.sv
// Bit-serial shifter: accepts an op over valid/ready, shifts one position per
// clock, and returns the result over a second valid/ready handshake.
module serial_shifter
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       control,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int unsigned SHMAX = 1 << SHW;
    localparam int unsigned CW    = $clog2((SHMAX > (WIDTH + 1)) ? SHMAX : (WIDTH + 1));

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    count;
    logic [CW-1:0]    n_eff;
    logic [1:0]       op;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] step_out;
    logic             accept;

    assign accept = in_valid && (state == IDLE);

    // Rotation is periodic; only true shifts saturate at WIDTH steps.
    always_comb begin
        n_eff = CW'(shamt);
        if (control != RR && 32'(shamt) >= WIDTH) begin
            n_eff = CW'(WIDTH);
        end
    end

    shift_step #(.WIDTH(WIDTH)) u_step (
        .control (op),
        .r_in    (work),
        .r_out   (step_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)            state_nxt = SHIFT;
            SHIFT:   if (count == CW'(0))   state_nxt = DONE;
            DONE:    if (out_ready)         state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Working register and step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op    <= LSL;
            work  <= '0;
            count <= '0;
        end else if (accept) begin
            op    <= control;
            work  <= data;
            count <= n_eff;
        end else if (state == SHIFT && count != CW'(0)) begin
            work  <= step_out;
            count <= count - CW'(1);
        end
    end

    assign out_data = work;

endmodule

// File: tb/tb_serial_shifter.sv
// Self-checking bench for serial_shifter: directed table, backpressure,
// mid-operation reset and randomized ops against a reference model.
module tb_serial_shifter;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned SHW   = 5;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       control;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    int checks;
    int errors;

    serial_shifter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .control   (control),
        .shamt     (shamt),
        .data      (data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] ctrl;
        int         sh;
        logic [7:0] din;
        logic [7:0] exp;
        int         lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference result computed from the operation's arithmetic meaning.
    function automatic logic [7:0] ref_result(input logic [1:0] c, input int s, input logic [7:0] d);
        int v;
        int k;
        case (c)
            2'b00: v = (s >= 8) ? 0 : (int'(d) << s);
            2'b01: v = (s >= 8) ? 0 : (int'(d) >> s);
            2'b10: v = int'($signed(d)) >>> ((s >= 8) ? 7 : s);
            default: begin
                k = s % 8;
                v = (int'(d) >> k) | (int'(d) << (8 - k));
            end
        endcase
        return 8'(v);
    endfunction

    function automatic int ref_latency(input logic [1:0] c, input int s);
        if (c == 2'b11) return s + 2;
        return ((s < 8) ? s : 8) + 2;
    endfunction

    // Issue one op, measure latency (accept edge counts as 1), check result,
    // optionally hold backpressure, then consume.
    task automatic run_op(input logic [1:0] c, input int s, input logic [7:0] d,
                          input logic [7:0] exp, input int exp_lat, input int hold,
                          input bit poke, input string name);
        int lat;
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({name, "_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        control  = c;
        shamt    = SHW'(s);
        data     = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        control  = 2'($urandom);
        shamt    = SHW'($urandom);
        data     = 8'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({name, "_data"}, 32'(out_data), 32'(exp));
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            if (poke) begin
                in_valid = 1'b1;
                data     = 8'($urandom);
                shamt    = SHW'($urandom);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk({name, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({name, "_hold_data"}, 32'(out_data), 32'(exp));
            chk({name, "_hold_inrdy"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, "_consumed"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    vec_t vecs[9];

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        control   = 2'b00;
        shamt     = '0;
        data      = '0;

        vecs[0] = '{2'b00, 3,  8'h81, 8'h08, 5};
        vecs[1] = '{2'b10, 2,  8'h90, 8'hE4, 4};
        vecs[2] = '{2'b01, 9,  8'h90, 8'h00, 10};
        vecs[3] = '{2'b11, 1,  8'h81, 8'hC0, 3};
        vecs[4] = '{2'b11, 9,  8'h81, 8'hC0, 11};
        vecs[5] = '{2'b11, 0,  8'h81, 8'h81, 2};
        vecs[6] = '{2'b10, 31, 8'h90, 8'hFF, 10};
        vecs[7] = '{2'b00, 8,  8'h7F, 8'h00, 10};
        vecs[8] = '{2'b10, 20, 8'h70, 8'h00, 10};

        #12;
        chk("rst_state", {28'd0, in_ready, out_valid, busy, 1'b0}, 32'b1000);
        chk("rst_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].ctrl, vecs[i].sh, vecs[i].din, vecs[i].exp, vecs[i].lat,
                   0, 1'b0, $sformatf("vec%0d", i));
        end

        // Backpressure for 5 clocks with ignored input pulses.
        run_op(2'b00, 3, 8'h81, 8'h08, 5, 5, 1'b1, "bp");
        chk("bp_idle_busy", 32'(busy), 32'd0);

        // Reset in the middle of a long shift.
        in_valid = 1'b1;
        control  = 2'b00;
        shamt    = SHW'(20);
        data     = 8'hFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst", {29'd0, in_ready, out_valid, busy}, 32'b100);
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) chk("mid_rst_no_pulse", 32'(out_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        run_op(2'b10, 3, 8'hA0, 8'hF4, 5, 0, 1'b0, "post_rst");

        // Randomized ops against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [1:0] c;
            int         s;
            logic [7:0] d;
            c = 2'($urandom);
            s = int'($urandom_range(0, 31));
            d = 8'($urandom);
            run_op(c, s, d, ref_result(c, s, d), ref_latency(c, s),
                   int'($urandom_range(0, 2)), 1'($urandom), $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
